pwm_ramp_ctrl: RTL
==================

Name: pwm_ramp_ctrl

Overview:
Soft-start/soft-stop sequencer between the switch conditioner and the PWM generator. It takes single-cycle increase, decrease and start/stop pulses and holds a target duty. It slews the applied duty toward that target at a fixed rate and reports the motor run state. Its duty_out drives the PWM generator's duty input and the decimal display path.

Parameters:
DUTY_W, 8, width of duty/target values
DUTY_MAX, 100, upper saturation for target and duty (percent)
STEP, 5, target change per increase/decrease pulse
DEFAULT_TARGET, 50, target value after reset
RAMP_DIV, 500000, clk cycles per 1-unit duty slew step (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
swt_increase  input  1  single-cycle pulse, raise target by STEP
swt_decrease  input  1  single-cycle pulse, lower target by STEP
swt_start_stop  input  1  single-cycle pulse, toggle run request
duty_out  output  DUTY_W  applied duty (0..DUTY_MAX)
target_out  output  DUTY_W  current target duty
motor_running  output  1  high in every state except IDLE
ramping  output  1  high while duty_out != slew goal and state != IDLE

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, duty_out=0, target_out=DEFAULT_TARGET, motor_running=0, ramping=0, prescaler=0. rst overrides all inputs in that cycle.
- Target register, all states:
  - swt_increase alone: target = min(target+STEP, DUTY_MAX).
  - swt_decrease alone: target = max(target-STEP, 0), with no underflow.
  - Both high in the same cycle: target unchanged.
  - Updated value is visible on target_out the next cycle.
- Prescaler: counts 0..RAMP_DIV-1 while state != IDLE. tick=1 for one cycle when count==RAMP_DIV-1, then wraps to 0. Forced to 0 in IDLE and on every state change.
- Slew goal: target in RAMP_UP/RUN; 0 in RAMP_DOWN. On tick, duty_out moves 1 toward goal. No change when equal.
- FSM (transitions registered, 1-cycle latency from pulse to new state):
  - IDLE: duty_out held 0. start_stop -> RAMP_UP.
  - RAMP_UP: slew toward target. When duty_out==target (checked every cycle, including a target of 0 on entry) -> RUN. start_stop -> RAMP_DOWN.
  - RUN: keep slewing toward target if it changes; ramping reflects the mismatch. start_stop -> RAMP_DOWN.
  - RAMP_DOWN: slew toward 0. duty_out==0 -> IDLE. start_stop -> RAMP_UP, reversing from the current duty with no jump.
- start_stop has priority over the duty-equality transition in the same cycle.
- Target changed in any state during ramping: the new goal applies from the next cycle. duty_out never exceeds DUTY_MAX or changes by more than 1 per tick.
- Inc/dec pulses concurrent with start_stop: both take effect in that cycle.
- Mid-operation reset: immediate return to reset values. duty_out drops to 0 without ramp.
- ramping, motor_running: combinational from registered state and registers, glitch-free relative to clk.

Decomposition:
- Package pwm_ctrl_pkg: state enum (IDLE, RAMP_UP, RUN, RAMP_DOWN), DUTY_W, DUTY_MAX, default STEP constants.
- One sub-module: ramp_tick (prescaler with clear input and tick output, parameter RAMP_DIV).
- FSM, target register and duty slew stay in pwm_ramp_ctrl.

Test Plan:
(All with RAMP_DIV=4, STEP=5, DEFAULT_TARGET=50.)
1. Reset, then idle 20 cycles -> duty_out=0, target_out=50, motor_running=0, ramping=0.
2. start_stop pulse -> motor_running=1 next cycle; duty_out increments every 4 cycles, reaches 50 after 200 cycles; state RUN, ramping=0.
3. In RUN at 50, 3 increase pulses -> target_out 55, 60, 65; duty_out slews to 65 in 60 cycles. Further increases stop target at 100. decrease at target 0 stays 0.
4. In RUN at 50, start_stop -> duty decrements to 0 in 200 cycles, then IDLE, motor_running=0. Second start_stop at duty 20 during RAMP_DOWN -> RAMP_UP from 20 with no jump.
5. increase and decrease in the same cycle -> target unchanged. increase with start_stop in IDLE -> target 55 and RAMP_UP both the next cycle.
6. rst asserted in RAMP_UP at duty 30 -> next cycle duty_out=0, target_out=50, IDLE. Target 0 then start_stop -> RAMP_UP then RUN next cycle with duty_out=0.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pwm_ctrl_pkg : shared state encoding and default sizing for the ramp control
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pwm_ctrl_pkg;

  localparam int DUTY_W_DEF   = 8;
  localparam int DUTY_MAX_DEF = 100;
  localparam int STEP_DEF     = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ramp_tick.sv
// ----------------------------------------------------------------------------
// ramp_tick : free-running prescaler, one-cycle tick every RAMP_DIV clocks
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ramp_tick #(
  parameter int RAMP_DIV = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(RAMP_DIV);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (r_count == c_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
// ----------------------------------------------------------------------------
// pwm_ramp_ctrl : soft-start/stop sequencer slewing applied duty toward target
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W         = DUTY_W_DEF,
  parameter int DUTY_MAX       = DUTY_MAX_DEF,
  parameter int STEP           = STEP_DEF,
  parameter int DEFAULT_TARGET = 50,
  parameter int RAMP_DIV       = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              swt_increase,
  input  logic              swt_decrease,
  input  logic              swt_start_stop,
  output logic [DUTY_W-1:0] duty_out,
  output logic [DUTY_W-1:0] target_out,
  output logic              motor_running,
  output logic              ramping
);

  localparam logic [DUTY_W-1:0] c_step      = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] c_max       = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] c_default   = DUTY_W'(DEFAULT_TARGET);
  localparam logic [DUTY_W-1:0] c_inc_limit = DUTY_W'(DUTY_MAX - STEP);

  state_t            r_state;
  state_t            w_state_next;
  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] r_target;
  logic [DUTY_W-1:0] w_goal;
  logic              w_clear;
  logic              w_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // start_stop is tested first so it wins over the duty-equality exits
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (swt_start_stop) w_state_next = RAMP_UP;
      end
      RAMP_UP: begin
        if (swt_start_stop)         w_state_next = RAMP_DOWN;
        else if (r_duty == r_target) w_state_next = RUN;
      end
      RUN: begin
        if (swt_start_stop) w_state_next = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (swt_start_stop)   w_state_next = RAMP_UP;
        else if (r_duty == '0) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Restart the slew interval on every state change so each phase starts clean
  assign w_clear = (r_state == IDLE) || (w_state_next != r_state);

  ramp_tick #(
    .RAMP_DIV(RAMP_DIV)
  ) u_ramp_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(w_clear),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_target <= c_default;
    end else if (swt_increase && !swt_decrease) begin
      r_target <= (r_target >= c_inc_limit) ? c_max : r_target + c_step;
    end else if (swt_decrease && !swt_increase) begin
      r_target <= (r_target < c_step) ? '0 : r_target - c_step;
    end
  end

  assign w_goal = (r_state == RAMP_DOWN) ? '0 : r_target;

  always_ff @(posedge clk) begin
    if (rst || (r_state == IDLE)) begin
      r_duty <= '0;
    end else if (w_tick) begin
      if (r_duty < w_goal) begin
        r_duty <= r_duty + 1'b1;
      end else if (r_duty > w_goal) begin
        r_duty <= r_duty - 1'b1;
      end
    end
  end

  assign duty_out      = r_duty;
  assign target_out    = r_target;
  assign motor_running = (r_state != IDLE);
  assign ramping       = (r_state != IDLE) && (r_duty != w_goal);

endmodule

`default_nettype wire
